// File: rtl/serial_twos_comp.sv
// Bit-serial two's-complement negate / pass-through over parallel lanes.
// LSB-first words share one framing; one-cycle registered result.
module serial_twos_comp #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                t_clk,
  input  logic                r_n,
  input  logic                in_valid,
  input  logic                sow,
  input  logic                mode,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic                out_valid,
  output logic                eow,
  output logic [CHANNELS-1:0] ovf,
  output logic                err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CHANNELS-1:0] seen;
  logic                mode_q;

  logic                start;
  logic                step;
  logic                last;
  logic [CHANNELS-1:0] flip;

  assign start = in_valid & sow;
  assign step  = in_valid & ~sow & (state == ACTIVE);
  assign last  = (cnt == CW'(WIDTH - 1));
  assign flip  = mode_q ? seen : '0;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state     <= IDLE;
      cnt       <= '0;
      seen      <= '0;
      mode_q    <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      eow       <= 1'b0;
      ovf       <= '0;
      err       <= 1'b0;
    end else begin
      dout      <= '0;
      out_valid <= 1'b0;
      eow       <= 1'b0;
      ovf       <= '0;
      err       <= 1'b0;
      unique case (1'b1)
        start: begin
          // a sow inside a word abandons it and restarts here
          err       <= (state == ACTIVE);
          out_valid <= 1'b1;
          dout      <= din;
          seen      <= din;
          mode_q    <= mode;
          cnt       <= CW'(1);
          state     <= ACTIVE;
        end
        step: begin
          out_valid <= 1'b1;
          dout      <= din ^ flip;
          seen      <= seen | din;
          if (last) begin
            eow   <= 1'b1;
            ovf   <= mode_q ? (din & ~seen) : '0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
